pll_phase_step_responder: RTL
=============================

Name: pll_phase_step_responder

Overview:
- Synthesizable responder for the PLL dynamic phase-shift port; it is the PLL-side end of the phasestep/phasedone handshake.
- Qualifies each phasestep request and answers with a phasedone low pulse of fixed length.
- Tracks the accumulated phase position and whole-period count.
- Serves as the PLL stand-in when verifying phase_shift_processor, and as a phase bookkeeper alongside the real PLL.

Parameters:
- PHASE_STEPS_PER_PERIOD, 8: phase steps per VCO period; position wraps at this value (≥2).
- MIN_STEP_HIGH, 2: consecutive high samples of i_phasestep needed to accept a step (≥1).
- DONE_LATENCY, 4: cycles o_phasedone is held low per accepted step (≥1).
- PERIOD_W, 8: width of the period counter.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_phasestep  in  1  step request from the initiator.
- i_updn  in  1  direction: 1 = advance, 0 = retard; sampled on the qualifying edge.
- o_phasedone  out  1  high = ready; low while a step is being applied.
- o_phase_pos  out  clog2(PHASE_STEPS_PER_PERIOD)  current phase position.
- o_period_cnt  out  PERIOD_W  signed-wrap count of whole periods crossed.
- o_busy  out  1  high from qualification until i_phasestep is released.
- o_step_err  out  1  one-cycle pulse when a request is dropped before qualification.

Behaviour:
- Reset (i_rst high at an edge):
  - o_phasedone=1; o_phase_pos=0; o_period_cnt=0; o_busy=0; o_step_err=0; state=IDLE.
  - Reset wins over every other event, including mid-BUSY; an in-flight step is discarded and position is not updated.
- IDLE:
  - o_phasedone=1.
  - i_phasestep sampled high → QUALIFY with hold count=1.
  - If MIN_STEP_HIGH=1, that same edge acts as the qualifying edge.
- QUALIFY:
  - Each edge with i_phasestep high increments the hold count.
  - On the edge where the count reaches MIN_STEP_HIGH → BUSY:
    - o_phasedone←0, o_busy←1, latency counter←DONE_LATENCY-1;
    - position updated on this same edge using i_updn.
  - i_phasestep sampled low before qualification → IDLE, o_step_err pulses 1 cycle, no position change.
- BUSY:
  - o_phasedone stays low for exactly DONE_LATENCY cycles, then → RELEASE with o_phasedone←1.
  - i_phasestep is ignored in BUSY, whether it stays high or drops early.
- RELEASE:
  - o_phasedone=1 and o_busy=1 until i_phasestep is sampled low; then → IDLE and o_busy←0.
  - Requests are edge-based: a request held high produces exactly one step.
- Advance (i_updn=1):
  - pos=STEPS-1 → pos=0 and o_period_cnt+1; otherwise pos+1.
- Retard (i_updn=0):
  - pos=0 → pos=STEPS-1 and o_period_cnt-1; otherwise pos-1.
- o_period_cnt wraps modulo 2^PERIOD_W in both directions (255+1→0, 0-1→255); no saturation.
- Timing: from the first high sample, o_phasedone falls MIN_STEP_HIGH-1 edges later. Minimum step-to-step spacing is MIN_STEP_HIGH+DONE_LATENCY+1 cycles.
- All outputs are registered; no combinational input-to-output path.

Optional Feature:
- Macro PHASE_RESP_STEP_COUNT_EN.
- Defined: adds output o_step_total [15:0].
  - Counts accepted steps in either direction, +1 on each qualifying edge.
  - Saturates at 16'hFFFF; reset to 0 by i_rst.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package phase_shift_pkg:
  - state encoding localparams IDLE/QUALIFY/BUSY/RELEASE;
  - default constants for steps-per-period, minimum step high time and done latency, shared with phase_shift_processor.
- One sub-module: phase_step_qualifier.
  - Covers the hold counter, drop detection, qualify pulse and err pulse.
  - Inputs i_clk, i_rst, i_phasestep, i_enable; outputs o_qualified, o_err.

Test Plan:
1. Reset, then i_phasestep high 6 cycles, i_updn=1 → o_phasedone falls at 2nd high edge, is low 4 cycles then rises; pos 0→1; exactly one step.
2. Eight advance steps from pos=0 → pos reads 1..7 then 0; o_period_cnt 0→1 on the 8th step.
3. One retard step from pos=0, o_period_cnt=0 → pos=7, o_period_cnt=255.
4. i_phasestep high for 1 cycle, then low → o_step_err pulses once; o_phasedone stays 1; pos unchanged.
5. i_rst asserted during the 2nd BUSY cycle → next edge: o_phasedone=1, pos=0, o_busy=0; a following valid step starts cleanly.
6. With PHASE_RESP_STEP_COUNT_EN defined, 3 advance + 2 retard steps → o_step_total=5, pos=1.

Source files
------------

// File: rtl/phase_shift_pkg.sv
// Shared definitions for the PLL phase-shift handshake: the responder state encoding
// and the default step geometry used by both ends of the phasestep/phasedone link.
package phase_shift_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } phase_state_e;

    localparam int DEF_STEPS_PER_PERIOD = 8;
    localparam int DEF_MIN_STEP_HIGH    = 2;
    localparam int DEF_DONE_LATENCY     = 4;
    localparam int DEF_PERIOD_W         = 8;

endpackage

// File: rtl/pll_phase_step_responder_if.sv
// Phase-step handshake bundle between an initiator (master) and the PLL-side responder (slave).
// o_step_total exists only when PHASE_RESP_STEP_COUNT_EN is defined.
interface pll_phase_step_responder_if
    import phase_shift_pkg::*;
#(
    parameter int POS_W    = $clog2(DEF_STEPS_PER_PERIOD),
    parameter int PERIOD_W = DEF_PERIOD_W
);
    logic                i_phasestep;
    logic                i_updn;
    logic                o_phasedone;
    logic [POS_W-1:0]    o_phase_pos;
    logic [PERIOD_W-1:0] o_period_cnt;
    logic                o_busy;
    logic                o_step_err;
`ifdef PHASE_RESP_STEP_COUNT_EN
    logic [15:0]         o_step_total;
`endif

    modport master (
        output i_phasestep, i_updn,
        input  o_phasedone, o_phase_pos, o_period_cnt, o_busy, o_step_err
`ifdef PHASE_RESP_STEP_COUNT_EN
        , input o_step_total
`endif
    );

    modport slave (
        input  i_phasestep, i_updn,
        output o_phasedone, o_phase_pos, o_period_cnt, o_busy, o_step_err
`ifdef PHASE_RESP_STEP_COUNT_EN
        , output o_step_total
`endif
    );

endinterface

// File: rtl/phase_step_qualifier.sv
// Counts consecutive high samples of phasestep while enabled; flags the qualifying
// edge and a request that drops before reaching the minimum hold time.
module phase_step_qualifier
    import phase_shift_pkg::*;
#(
    parameter int MIN_STEP_HIGH = DEF_MIN_STEP_HIGH
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_phasestep,
    input  logic i_enable,
    output logic o_qualified,
    output logic o_err
);
    localparam int               CNT_W    = $clog2(MIN_STEP_HIGH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MIN_STEP_HIGH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] hold_cnt_r;

    // Qualify and drop decisions act on the current sample so the caller can react on this edge.
    always_comb begin
        o_qualified = i_enable && i_phasestep && (hold_cnt_r == CNT_LAST);
        o_err       = i_enable && !i_phasestep && (hold_cnt_r != {CNT_W{1'b0}});
    end

    // Hold counter: restarts whenever the request is not being accumulated.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_cnt_r <= {CNT_W{1'b0}};
        end else if (!i_enable || !i_phasestep || o_qualified) begin
            hold_cnt_r <= {CNT_W{1'b0}};
        end else begin
            hold_cnt_r <= hold_cnt_r + CNT_ONE;
        end
    end

endmodule

// File: rtl/pll_phase_step_responder.sv
// PLL-side phasestep/phasedone responder with phase position and period bookkeeping.
// Optional accepted-step counter enabled by defining PHASE_RESP_STEP_COUNT_EN.
module pll_phase_step_responder
    import phase_shift_pkg::*;
#(
    parameter int PHASE_STEPS_PER_PERIOD = DEF_STEPS_PER_PERIOD,
    parameter int MIN_STEP_HIGH          = DEF_MIN_STEP_HIGH,
    parameter int DONE_LATENCY           = DEF_DONE_LATENCY,
    parameter int PERIOD_W               = DEF_PERIOD_W
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    pll_phase_step_responder_if.slave   bus
);
    localparam int                  POS_W    = $clog2(PHASE_STEPS_PER_PERIOD);
    localparam logic [POS_W-1:0]    POS_MAX  = POS_W'(PHASE_STEPS_PER_PERIOD - 1);
    localparam logic [POS_W-1:0]    POS_ONE  = POS_W'(1);
    localparam logic [PERIOD_W-1:0] PER_ONE  = PERIOD_W'(1);
    localparam int                  LAT_W    = (DONE_LATENCY > 1) ? $clog2(DONE_LATENCY) : 1;
    localparam logic [LAT_W-1:0]    LAT_INIT = LAT_W'(DONE_LATENCY - 1);
    localparam logic [LAT_W-1:0]    LAT_ONE  = LAT_W'(1);

    phase_state_e        state_r, state_nxt_s;
    logic [LAT_W-1:0]    lat_r, lat_nxt_s;
    logic [POS_W-1:0]    pos_r, pos_nxt_s;
    logic [PERIOD_W-1:0] period_r, period_nxt_s;
    logic                phasedone_r, busy_r, step_err_r;
    logic                qual_s, err_s, enable_s;

    assign enable_s = (state_r == IDLE) || (state_r == QUALIFY);

    phase_step_qualifier #(.MIN_STEP_HIGH(MIN_STEP_HIGH)) u_qualifier (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_phasestep (bus.i_phasestep),
        .i_enable    (enable_s),
        .o_qualified (qual_s),
        .o_err       (err_s)
    );

    // Next state, latency countdown and phase position update on the qualifying edge.
    always_comb begin
        state_nxt_s  = state_r;
        lat_nxt_s    = lat_r;
        pos_nxt_s    = pos_r;
        period_nxt_s = period_r;
        case (state_r)
            IDLE, QUALIFY: begin
                if (qual_s) begin
                    state_nxt_s = BUSY;
                    lat_nxt_s   = LAT_INIT;
                    if (bus.i_updn) begin
                        if (pos_r == POS_MAX) begin
                            pos_nxt_s    = {POS_W{1'b0}};
                            period_nxt_s = period_r + PER_ONE;
                        end else begin
                            pos_nxt_s = pos_r + POS_ONE;
                        end
                    end else begin
                        if (pos_r == {POS_W{1'b0}}) begin
                            pos_nxt_s    = POS_MAX;
                            period_nxt_s = period_r - PER_ONE;
                        end else begin
                            pos_nxt_s = pos_r - POS_ONE;
                        end
                    end
                end else if (bus.i_phasestep) begin
                    state_nxt_s = QUALIFY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (lat_r == {LAT_W{1'b0}}) begin
                    state_nxt_s = RELEASE;
                end else begin
                    lat_nxt_s = lat_r - LAT_ONE;
                end
            end
            RELEASE: begin
                if (!bus.i_phasestep) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RELEASE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they change with it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= IDLE;
            lat_r       <= {LAT_W{1'b0}};
            pos_r       <= {POS_W{1'b0}};
            period_r    <= {PERIOD_W{1'b0}};
            phasedone_r <= 1'b1;
            busy_r      <= 1'b0;
            step_err_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            lat_r       <= lat_nxt_s;
            pos_r       <= pos_nxt_s;
            period_r    <= period_nxt_s;
            phasedone_r <= (state_nxt_s != BUSY);
            busy_r      <= (state_nxt_s == BUSY) || (state_nxt_s == RELEASE);
            step_err_r  <= err_s;
        end
    end

    assign bus.o_phasedone  = phasedone_r;
    assign bus.o_phase_pos  = pos_r;
    assign bus.o_period_cnt = period_r;
    assign bus.o_busy       = busy_r;
    assign bus.o_step_err   = step_err_r;

`ifdef PHASE_RESP_STEP_COUNT_EN
    logic [15:0] step_total_r;

    // Accepted-step counter, saturating at all ones.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            step_total_r <= 16'h0000;
        end else if (qual_s && (step_total_r != 16'hFFFF)) begin
            step_total_r <= step_total_r + 16'h0001;
        end else begin
            step_total_r <= step_total_r;
        end
    end

    assign bus.o_step_total = step_total_r;
`endif

endmodule
